// File: rtl/comparator_sweep_ctrl.sv
// Exhaustive self-test sequencer for a WIDTH-bit magnitude comparator.
// Walks every (A,B) pair, waits SETTLE cycles, then checks the six flags.
module comparator_sweep_ctrl #(
    parameter int WIDTH  = 3,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] dec_a,
    output logic [WIDTH-1:0] dec_b,
    input  logic             a_gt_b,
    input  logic             a_ge_b,
    input  logic             a_lt_b,
    input  logic             a_le_b,
    input  logic             a_eq_b,
    input  logic             a_ne_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err;
    logic             r_fail_valid;
    logic [WIDTH-1:0] r_fail_a;
    logic [WIDTH-1:0] r_fail_b;

    logic [5:0]       w_exp;
    logic [5:0]       w_got;
    logic             w_mismatch;
    logic             w_last;
    logic [ERR_W-1:0] w_err_nxt;

    assign w_exp = {r_a > r_b, r_a >= r_b, r_a < r_b,
                    r_a <= r_b, r_a == r_b, r_a != r_b};
    assign w_got = {a_gt_b, a_ge_b, a_lt_b, a_le_b, a_eq_b, a_ne_b};
    assign w_mismatch = (w_exp != w_got);
    assign w_last = (&r_a) && (&r_b);

    // One count per failing pair, saturating.
    always_comb begin
        w_err_nxt = r_err;
        if (w_mismatch && (r_err != ERR_MAX)) begin
            w_err_nxt = r_err + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a          <= '0;
                        r_b          <= '0;
                        r_err        <= '0;
                        r_fail_valid <= 1'b0;
                        r_fail_a     <= '0;
                        r_fail_b     <= '0;
                        r_pass       <= 1'b0;
                        r_cnt        <= CNT_LOAD;
                        r_busy       <= 1'b1;
                        r_state      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_CHECK: begin
                    r_err <= w_err_nxt;
                    if (w_mismatch && !r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_fail_a     <= r_a;
                        r_fail_b     <= r_b;
                    end
                    if (w_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_nxt == '0);
                        r_state <= S_DONE;
                    end else begin
                        r_b <= r_b + WIDTH'(1);
                        if (&r_b) begin
                            r_a <= r_a + WIDTH'(1);
                        end
                        r_cnt   <= CNT_LOAD;
                        r_state <= S_WAIT;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign dec_a      = r_a;
    assign dec_b      = r_b;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err;
    assign fail_valid = r_fail_valid;
    assign fail_a     = r_fail_a;
    assign fail_b     = r_fail_b;

endmodule

// File: tb/tb_comparator_sweep_ctrl.sv
// Bench for comparator_sweep_ctrl: default, SETTLE=3 and ERR_W=3 instances
// driven by a faultable comparator model and checked against a pair-loop model.
module tb_comparator_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       st [3];
    logic [2:0] da [3];
    logic [2:0] db [3];
    logic       bz [3];
    logic       dn [3];
    logic       ps [3];
    logic       fv [3];
    logic [2:0] fa [3];
    logic [2:0] fb [3];
    logic [7:0] e0;
    logic [7:0] e1;
    logic [2:0] e2;
    logic [5:0] fl [3];

    int         mode;
    logic [5:0] mask [64];
    int         sel;
    int         checks;
    int         failures;

    // bits: 5 gt, 4 ge, 3 lt, 2 le, 1 eq, 0 ne
    function automatic logic [5:0] flag_model(input int m, input logic [5:0] msk,
                                              input logic [2:0] a, input logic [2:0] b);
        logic [5:0] f;
        f = {a > b, a >= b, a < b, a <= b, a == b, a != b};
        case (m)
            1: f[1] = 1'b0;
            2: if (a == 3'd6 && b == 3'd2) f[3] = ~f[3];
            3: f = ~f;
            4: f = f ^ msk;
            default: ;
        endcase
        return f;
    endfunction

    assign fl[0] = flag_model(mode, mask[{da[0], db[0]}], da[0], db[0]);
    assign fl[1] = flag_model(mode, mask[{da[1], db[1]}], da[1], db[1]);
    assign fl[2] = flag_model(mode, mask[{da[2], db[2]}], da[2], db[2]);

    comparator_sweep_ctrl u_dut (
        .clk(clk), .reset(reset), .start(st[0]),
        .dec_a(da[0]), .dec_b(db[0]),
        .a_gt_b(fl[0][5]), .a_ge_b(fl[0][4]), .a_lt_b(fl[0][3]),
        .a_le_b(fl[0][2]), .a_eq_b(fl[0][1]), .a_ne_b(fl[0][0]),
        .busy(bz[0]), .done(dn[0]), .pass(ps[0]), .err_count(e0),
        .fail_valid(fv[0]), .fail_a(fa[0]), .fail_b(fb[0])
    );

    comparator_sweep_ctrl #(.SETTLE(3)) u_s3 (
        .clk(clk), .reset(reset), .start(st[1]),
        .dec_a(da[1]), .dec_b(db[1]),
        .a_gt_b(fl[1][5]), .a_ge_b(fl[1][4]), .a_lt_b(fl[1][3]),
        .a_le_b(fl[1][2]), .a_eq_b(fl[1][1]), .a_ne_b(fl[1][0]),
        .busy(bz[1]), .done(dn[1]), .pass(ps[1]), .err_count(e1),
        .fail_valid(fv[1]), .fail_a(fa[1]), .fail_b(fb[1])
    );

    comparator_sweep_ctrl #(.ERR_W(3)) u_e3 (
        .clk(clk), .reset(reset), .start(st[2]),
        .dec_a(da[2]), .dec_b(db[2]),
        .a_gt_b(fl[2][5]), .a_ge_b(fl[2][4]), .a_lt_b(fl[2][3]),
        .a_le_b(fl[2][2]), .a_eq_b(fl[2][1]), .a_ne_b(fl[2][0]),
        .busy(bz[2]), .done(dn[2]), .pass(ps[2]), .err_count(e2),
        .fail_valid(fv[2]), .fail_a(fa[2]), .fail_b(fb[2])
    );

    logic [2:0] o_a, o_b, o_fa, o_fb;
    logic       o_busy, o_done, o_pass, o_fv;
    logic [7:0] o_err;

    always_comb begin
        o_a    = da[sel];
        o_b    = db[sel];
        o_fa   = fa[sel];
        o_fb   = fb[sel];
        o_busy = bz[sel];
        o_done = dn[sel];
        o_pass = ps[sel];
        o_fv   = fv[sel];
        o_err  = (sel == 0) ? e0 : (sel == 1) ? e1 : {5'b0, e2};
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        int v;
        v = int'({o_a, o_b, o_fa, o_fb, o_busy, o_done, o_pass, o_fv, o_err});
        chk(name, v, 0);
    endtask

    // Reference: walk all 64 pairs, compare the comparator model to true compares.
    task automatic ref_model(input int m, input int errw, output int err, output int rfv,
                             output int rfa, output int rfb, output int rpass);
        int sat;
        sat = (1 << errw) - 1;
        err = 0; rfv = 0; rfa = 0; rfb = 0;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                logic [5:0] want;
                logic [5:0] got;
                want = {a > b, a >= b, a < b, a <= b, a == b, a != b};
                got  = flag_model(m, mask[a*8+b], 3'(a), 3'(b));
                if (got != want) begin
                    if (err < sat) err++;
                    if (rfv == 0) begin rfv = 1; rfa = a; rfb = b; end
                end
            end
        end
        rpass = (err == 0) ? 1 : 0;
    endtask

    task automatic check_res(input string tag, input int err, input int efv,
                             input int efa, input int efb, input int epass);
        chk({tag, ".err"}, int'(o_err), err);
        chk({tag, ".fail_valid"}, int'(o_fv), efv);
        if (efv != 0) begin
            chk({tag, ".fail_a"}, int'(o_fa), efa);
            chk({tag, ".fail_b"}, int'(o_fb), efb);
        end
        chk({tag, ".pass"}, int'(o_pass), epass);
    endtask

    task automatic sweep(input int settle, input bit inject, output int busy_n,
                         output int done_n, output int done_cyc, output int order_err);
        int idx;
        busy_n = 0; done_n = 0; done_cyc = -1; order_err = 0;
        @(negedge clk);
        st[sel] = 1'b1;
        @(negedge clk);
        st[sel] = 1'b0;
        for (int cyc = 1; cyc < 1200; cyc++) begin
            if (o_busy) begin
                busy_n++;
                idx = (cyc - 1) / (settle + 1);
                if (int'(o_a) != idx / 8 || int'(o_b) != idx % 8) order_err++;
            end
            if (o_done) begin
                done_n++;
                done_cyc = cyc;
            end
            st[sel] = (inject && (cyc == 10 || cyc == 60)) ? 1'b1 : 1'b0;
            if (done_cyc > 0 && cyc >= done_cyc + 3) break;
            @(negedge clk);
        end
    endtask

    typedef struct {
        int mode;
        int err;
        int fv;
        int fa;
        int fb;
        int pass;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int bn, dnn, dc, oe;
        int rerr, rfv, rfa, rfb, rpass;
        bit found;
        checks = 0; failures = 0;
        sel = 0; mode = 0; reset = 1'b1;
        for (int i = 0; i < 3; i++) st[i] = 1'b0;
        for (int i = 0; i < 64; i++) mask[i] = '0;

        tbl[0] = '{0, 0, 0, 0, 0, 1};
        tbl[1] = '{1, 8, 1, 0, 0, 0};
        tbl[2] = '{2, 1, 1, 6, 2, 0};
        tbl[3] = '{0, 0, 0, 0, 0, 1};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                sel = s;
                #0 chk_zero($sformatf("reset_idle.c%0d.i%0d", c, s));
            end
        end
        sel = 0;

        for (int i = 0; i < 4; i++) begin
            mode = tbl[i].mode;
            sweep(1, i == 0, bn, dnn, dc, oe);
            chk($sformatf("vec%0d.busy_cycles", i), bn, 128);
            chk($sformatf("vec%0d.done_count", i), dnn, 1);
            chk($sformatf("vec%0d.done_cycle", i), dc, 129);
            chk($sformatf("vec%0d.pair_order", i), oe, 0);
            chk($sformatf("vec%0d.final_ab", i), int'({o_a, o_b}), 63);
            check_res($sformatf("vec%0d", i), tbl[i].err, tbl[i].fv,
                      tbl[i].fa, tbl[i].fb, tbl[i].pass);
        end

        mode = 4;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 64; i++) begin
                mask[i] = ($urandom_range(0, 3) == 0 && r != 0) ?
                          6'($urandom_range(1, 63)) : 6'd0;
            end
            ref_model(4, 8, rerr, rfv, rfa, rfb, rpass);
            sweep(1, 1'b0, bn, dnn, dc, oe);
            chk($sformatf("rand%0d.done_cycle", r), dc, 129);
            check_res($sformatf("rand%0d", r), rerr, rfv, rfa, rfb, rpass);
        end
        for (int i = 0; i < 64; i++) mask[i] = '0;

        sel = 1; mode = 0;
        sweep(3, 1'b0, bn, dnn, dc, oe);
        chk("settle3.busy_cycles", bn, 256);
        chk("settle3.done_cycle", dc, 257);
        chk("settle3.pair_order", oe, 0);
        check_res("settle3", 0, 0, 0, 0, 1);

        sel = 2; mode = 3;
        sweep(1, 1'b0, bn, dnn, dc, oe);
        chk("errw3.done_cycle", dc, 129);
        check_res("errw3", 7, 1, 0, 0, 0);

        sel = 0; mode = 0;
        @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (o_a == 3'd3 && o_b == 3'd4) begin found = 1'b1; break; end
            @(negedge clk);
        end
        chk("midreset.reach_3_4", int'(found), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_zero("midreset.outputs");
        @(negedge clk);
        chk_zero("midreset.stays_idle");
        mode = 1;
        sweep(1, 1'b0, bn, dnn, dc, oe);
        chk("restart.pair_order", oe, 0);
        chk("restart.done_cycle", dc, 129);
        check_res("restart", 8, 1, 0, 0, 0);

        mode = 0;
        @(negedge clk);
        st[0] = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (o_done) begin found = 1'b1; break; end
        end
        chk("heldstart.done_seen", int'(found), 1);
        @(negedge clk);
        chk("heldstart.idle_busy", int'(o_busy), 0);
        @(negedge clk);
        chk("heldstart.restart_busy", int'(o_busy), 1);
        chk("heldstart.restart_ab", int'({o_a, o_b}), 0);
        st[0] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
